secuenciador_alu: RTL
=====================

Name: secuenciador_alu

Overview:
- Hardware initiator for the register-bank/ALU datapath; replaces hand-driven init/RegWrite stimulus.
- Holds a small program of ALU instructions and issues each one to the datapath with the init → wait alu_done → RegWrite handshake, then advances the PC.
- Sits beside top_con_banco_registro; its outputs wire directly to that block's control/address inputs.

Parameters:
- PC_W, 4, program address width; program depth = 2^PC_W.
- TIMEOUT, 64, max WAIT cycles before error (used only with the watchdog macro).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins execution at PC 0.
- prog_we  input  1  program-memory write enable.
- prog_addr  input  PC_W  program-memory write address.
- prog_data  input  16  instruction word: [15:14] selector, [13:10] addrRa, [9:6] addrRb, [5:2] addrW, [1] halt, [0] reserved.
- alu_done  input  1  datapath result-ready strobe.
- init  output  1  one-cycle operation-start pulse to the datapath.
- RegWrite  output  1  one-cycle register-bank write strobe.
- selector  output  2  ALU operation.
- addrRa, addrRb, addrW  output  4 each  register addresses.
- pc  output  PC_W  address of the current instruction.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the program ends.
- error  output  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE.
  - pc, init, RegWrite, selector, addr*, busy, done, error all 0.
  - Program memory is not cleared.
- States and transitions:
  - IDLE: on start → FETCH, pc=0, error cleared.
  - FETCH (1 cycle): register mem[pc] into the instruction register.
    - halt=1 → DONE.
    - halt=0 → ISSUE.
  - ISSUE (1 cycle): selector/addr* driven from the instruction register; init=1.
  - WAIT: init=0, selector/addr* held stable. alu_done=1 → WRITE.
  - WRITE (1 cycle): RegWrite=1, addr* still held.
    - pc==2^PC_W-1 → DONE.
    - Otherwise pc+1 → FETCH.
  - DONE (1 cycle): done=1, pc=0 → IDLE.
- Latency:
  - start sampled at edge N → init high during cycle N+2.
  - alu_done sampled at edge M → RegWrite high during cycle M+1.
- Handshake rules:
  - alu_done is sampled only in WAIT; assertions in any other state are ignored.
  - start while busy=1 is ignored.
  - prog_we while busy=1 is ignored, so the memory is never modified mid-run.
  - prog_we in IDLE writes on the clock edge; a simultaneous start fetches the old word at address 0 only if prog_addr≠0, otherwise the new word.
- selector/addr* hold their last values in IDLE and DONE; they are zeroed only by reset.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no RegWrite is completed.

Optional Feature:
- SECUENCIADOR_WATCHDOG_EN defined:
  - A counter runs in WAIT.
  - After TIMEOUT cycles without alu_done: error=1, FSM → IDLE with no RegWrite and no done pulse.
  - error stays high until the next accepted start or reset.
- Undefined: WAIT waits indefinitely; error is tied to 0 and no counter is built.

Decomposition:
- Shared package/include:
  - state encodings (IDLE, FETCH, ISSUE, WAIT, WRITE, DONE);
  - instruction field bit positions;
  - selector codes (00 suma, 01 resta, 10 and, 11 or).
- Sub-module memoria_programa: 2^PC_W×16 synchronous-write, asynchronous-read array. FSM and PC stay in the top-level.

Test Plan:
1. Load mem[0]=suma Ra=1 Rb=2 W=3, mem[1]=halt; pulse start; alu_done 3 cycles after init → init exactly 1 cycle, RegWrite 1 cycle with addrW=3, then done pulse, busy falls, pc=0.
2. Fill all 16 words with halt=0, alu_done returned 1 cycle after each init → 16 init/RegWrite pairs, pc 0..15, done after pc=15 (wrap), no 17th init.
3. start and prog_we pulsed during WAIT of instruction 0 → no restart, mem unchanged (readback via rerun), sequence completes normally.
4. alu_done asserted in the ISSUE cycle only, then low → FSM stays in WAIT, no RegWrite; a later alu_done → WRITE.
5. rst=0 for one cycle during WAIT → all outputs 0 immediately (mid-cycle), IDLE; a new start runs the program from pc=0.
6. With SECUENCIADOR_WATCHDOG_EN and TIMEOUT=64, alu_done never asserted → error=1 after 64 WAIT cycles, no RegWrite, no done; next start clears error.

Source files
------------

// File: rtl/secuenciador_alu_pkg.sv
// Shared definitions for the ALU instruction sequencer: FSM encodings,
// instruction field positions, ALU selector codes and an instruction builder.
package secuenciador_alu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SEL_SUMA  = 2'b00,
    SEL_RESTA = 2'b01,
    SEL_AND   = 2'b10,
    SEL_OR    = 2'b11
  } sel_t;

  localparam int INSTR_W  = 16;
  localparam int SEL_HI   = 15;
  localparam int SEL_LO   = 14;
  localparam int RA_HI    = 13;
  localparam int RA_LO    = 10;
  localparam int RB_HI    = 9;
  localparam int RB_LO    = 6;
  localparam int W_HI     = 5;
  localparam int W_LO     = 2;
  localparam int HALT_BIT = 1;
  localparam int RSVD_BIT = 0;

  function automatic logic [INSTR_W-1:0] mk_instr(input logic [1:0] sel,
                                                  input logic [3:0] ra,
                                                  input logic [3:0] rb,
                                                  input logic [3:0] w,
                                                  input logic       halt);
    return {sel, ra, rb, w, halt, 1'b0};
  endfunction

endpackage

// File: rtl/secuenciador_alu_memoria_programa.sv
// Program store: 2^AW x 16 words, written on the clock edge, read combinationally.
// Contents are deliberately not reset so a loaded program survives a reset.
module memoria_programa #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata
);

  logic [15:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/secuenciador_alu.sv
// Sequencer that walks a stored ALU program and drives the init / alu_done /
// RegWrite handshake of the datapath. Optional watchdog: SECUENCIADOR_WATCHDOG_EN.
//
// Handshake: init is a one-cycle request pulse; the datapath answers with a
// one-cycle alu_done strobe, which is only sampled while the FSM is in WAIT;
// RegWrite follows in the next cycle. Operand addresses are held stable from
// ISSUE until the next instruction is issued.
module secuenciador_alu
  import secuenciador_alu_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [15:0]     prog_data,
  input  logic            alu_done,
  output logic            init,
  output logic            RegWrite,
  output logic [1:0]      selector,
  output logic [3:0]      addrRa,
  output logic [3:0]      addrRb,
  output logic [3:0]      addrW,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            done,
  output logic            error,
  output state_t          dbg_state
);

  state_t          r_state;
  state_t          w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_next_pc;
  logic [15:0]     w_rdata;
  logic            w_load_ir;
  logic            w_mem_we;
  logic [1:0]      r_sel;
  logic [3:0]      r_ra;
  logic [3:0]      r_rb;
  logic [3:0]      r_w;
  logic            w_unused_ok;

`ifdef SECUENCIADOR_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            w_wd_fire;
  logic            w_start_ok;
  logic            r_error;
`endif

  // Program memory only accepts writes while idle, so a running program is frozen.
  assign w_mem_we = prog_we && (r_state == S_IDLE);

  memoria_programa #(
    .AW(PC_W)
  ) u_memoria_programa (
    .clk    (clk),
    .i_we   (w_mem_we),
    .i_waddr(prog_addr),
    .i_wdata(prog_data),
    .i_raddr(r_pc),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_load_ir    = 1'b0;
`ifdef SECUENCIADOR_WATCHDOG_EN
    w_wd_fire    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_FETCH;
          w_next_pc    = '0;
        end
      end
      S_FETCH: begin
        if (w_rdata[HALT_BIT]) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_ISSUE;
          w_load_ir    = 1'b1;
        end
      end
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT: begin
        if (alu_done) begin
          w_next_state = S_WRITE;
`ifdef SECUENCIADOR_WATCHDOG_EN
        end else if (r_wd_cnt == WD_W'(TIMEOUT - 1)) begin
          w_next_state = S_IDLE;
          w_wd_fire    = 1'b1;
`endif
        end
      end
      S_WRITE: begin
        if (r_pc == {PC_W{1'b1}}) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_FETCH;
          w_next_pc    = r_pc + PC_W'(1);
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        w_next_pc    = '0;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // A halt word is never latched, so the operand outputs keep the last real instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel <= '0;
      r_ra  <= '0;
      r_rb  <= '0;
      r_w   <= '0;
    end else if (w_load_ir) begin
      r_sel <= w_rdata[SEL_HI:SEL_LO];
      r_ra  <= w_rdata[RA_HI:RA_LO];
      r_rb  <= w_rdata[RB_HI:RB_LO];
      r_w   <= w_rdata[W_HI:W_LO];
    end
  end

`ifdef SECUENCIADOR_WATCHDOG_EN
  assign w_start_ok = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end else begin
      r_wd_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_error <= 1'b0;
    end else if (w_start_ok) begin
      r_error <= 1'b0;
    end else if (w_wd_fire) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign init      = (r_state == S_ISSUE);
  assign RegWrite  = (r_state == S_WRITE);
  assign done      = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign selector  = r_sel;
  assign addrRa    = r_ra;
  assign addrRb    = r_rb;
  assign addrW     = r_w;
  assign pc        = r_pc;
  assign dbg_state = r_state;

  assign w_unused_ok = &{1'b0, w_rdata[RSVD_BIT], (TIMEOUT > 0)};

endmodule
